reg_file_dof: RTL and testbench

- Upstream neighbour of the function unit: a 2-read/1-write register file plus the decode/operand-fetch output register.
- Each cycle it reads two source registers, optionally replaces operand B with a constant, and registers both operands onto the function unit's A and B buses.
- It accepts one write-back per cycle from the execute/write-back path.
- Stall holds the operands; flush zeroes them.

---
 rtl/reg_file_dof.sv | 80 ++++++++
 tb/tb_reg_file_dof.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_dof.sv
// Decode/operand-fetch stage: a 2-read/1-write register file (R0 reads as zero)
// feeding registered A/B operand buses. Optional macro: REGFILE_BYPASS_EN (write-through bypass).
module reg_file_dof #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              b_sel_const,
  input  logic [DATA_W-1:0] const_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              op_valid
);

  if (NUM_REGS < 2 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_cfg
    $error("reg_file_dof: NUM_REGS must be in [2, 2**ADDR_W]");
  end

  // R0 is not stored; it is the default value of every read mux.
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];
  logic [DATA_W-1:0] read_a;
  logic [DATA_W-1:0] read_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_en && wr_addr == ADDR_W'(i)) regs[i] <= wr_data;
      end
    end
  end

  // Addresses 0 and >= NUM_REGS never match a loop index, so they read as zero.
  always_comb begin
    read_a = '0;
    read_b = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rd_addr_a == ADDR_W'(i)) read_a = regs[i];
      if (rd_addr_b == ADDR_W'(i)) read_b = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wr_en && wr_addr == ADDR_W'(i)) begin
        if (rd_addr_a == wr_addr) read_a = wr_data;
        if (rd_addr_b == wr_addr) read_b = wr_data;
      end
    end
`endif
  end

  // op_valid qualifies a_out/b_out; there is no ready, the consumer holds us via stall.
  // Flush outranks stall; writes above are never blocked by either.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out    <= '0;
      b_out    <= '0;
      op_valid <= 1'b0;
    end else if (flush) begin
      a_out    <= '0;
      b_out    <= '0;
      op_valid <= 1'b0;
    end else if (!stall) begin
      a_out    <= read_a;
      b_out    <= b_sel_const ? const_in : read_b;
      op_valid <= rd_valid;
    end
  end

endmodule

// File: tb/tb_reg_file_dof.sv
// Directed bench for reg_file_dof: expected operand triples are queued when a
// fetch is driven and popped one edge later. Second instance uses NUM_REGS=16.
module tb_reg_file_dof;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0, flush = 1'b0, rd_valid = 1'b0, b_sel_const = 1'b0, wr_en = 1'b0;
  logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0;
  logic [DW-1:0] const_in = '0, wr_data = '0;
  logic [DW-1:0] a_out, b_out, a16, b16;
  logic          op_valid, v16;

  int checks = 0;
  int failures = 0;
  logic [2*DW:0] exp_q[$];

  always #5 clk = ~clk;

  reg_file_dof #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .rd_valid(rd_valid),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .b_sel_const(b_sel_const),
    .const_in(const_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .a_out(a_out), .b_out(b_out), .op_valid(op_valid));

  reg_file_dof #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(16)) dut16 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .rd_valid(rd_valid),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .b_sel_const(b_sel_const),
    .const_in(const_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .a_out(a16), .b_out(b16), .op_valid(v16));

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expected {op_valid, a_out, b_out}, clock once, then score the head.
  task automatic cycle(input string tag, input logic ev, input logic [DW-1:0] ea,
                       input logic [DW-1:0] eb);
    logic [2*DW:0] e;
    exp_q.push_back({ev, ea, eb});
    tick();
    e = exp_q.pop_front();
    check({tag, "_valid"}, DW'(op_valid), DW'(e[2*DW]));
    check({tag, "_a"}, a_out, e[2*DW-1:DW]);
    check({tag, "_b"}, b_out, e[DW-1:0]);
  endtask

  task automatic set_fetch(input int a, input int b, input logic sel, input logic [DW-1:0] c,
                           input logic v);
    rd_addr_a = AW'(a);
    rd_addr_b = AW'(b);
    b_sel_const = sel;
    const_in = c;
    rd_valid = v;
  endtask

  task automatic set_write(input logic en, input int addr, input logic [DW-1:0] data);
    wr_en = en;
    wr_addr = AW'(addr);
    wr_data = data;
  endtask

  task automatic write_reg(input int addr, input logic [DW-1:0] data);
    set_fetch(0, 0, 1'b0, '0, 1'b0);
    set_write(1'b1, addr, data);
    tick();
    set_write(1'b0, 0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_valid", DW'(op_valid), 0);
    check("rst_a", a_out, 0);
    check("rst_b", b_out, 0);
    rst = 1'b0;

    // Asynchronous reset mid-cycle, with a write in flight
    write_reg(1, 32'h0000_1234);
    set_fetch(1, 0, 1'b0, '0, 1'b1);
    cycle("pre_rst", 1'b1, 32'h1234, 32'h0);
    set_write(1'b1, 2, 32'hAAAA_AAAA);
    #2 rst = 1'b1;
    #1;
    check("async_rst_a", a_out, 0);
    check("async_rst_b", b_out, 0);
    check("async_rst_valid", DW'(op_valid), 0);
    tick();
    rst = 1'b0;
    set_write(1'b0, 0, '0);
    for (int i = 1; i < 32; i++) begin
      set_fetch(i, 32 - i, 1'b0, '0, 1'b1);
      cycle("rst_clear", 1'b1, 32'h0, 32'h0);
    end

    // Write/read and R0
    write_reg(5, 32'hDEAD_BEEF);
    write_reg(0, 32'hFFFF_FFFF);
    set_fetch(5, 0, 1'b0, '0, 1'b1);
    cycle("rd_r5_r0", 1'b1, 32'hDEAD_BEEF, 32'h0);
    set_fetch(0, 5, 1'b0, '0, 1'b1);
    cycle("rd_r0_r5", 1'b1, 32'h0, 32'hDEAD_BEEF);

    // Constant select, both ports on one register, rd_valid low
    write_reg(3, 32'd7);
    set_fetch(3, 5, 1'b1, 32'h0000_0010, 1'b1);
    cycle("const", 1'b1, 32'd7, 32'h10);
    set_fetch(0, 5, 1'b1, 32'hFFFF_FFF0, 1'b1);
    cycle("const_full", 1'b1, 32'h0, 32'hFFFF_FFF0);
    set_fetch(3, 3, 1'b0, '0, 1'b1);
    cycle("same_reg", 1'b1, 32'd7, 32'd7);
    set_fetch(5, 3, 1'b0, '0, 1'b0);
    cycle("no_valid", 1'b0, 32'hDEAD_BEEF, 32'd7);

    // Stall holds while R5 is rewritten, then flush beats stall
    set_fetch(5, 3, 1'b0, '0, 1'b1);
    cycle("fetch_r5", 1'b1, 32'hDEAD_BEEF, 32'd7);
    stall = 1'b1;
    set_fetch(3, 5, 1'b0, '0, 1'b0);
    set_write(1'b1, 5, 32'h1);
    cycle("stall1", 1'b1, 32'hDEAD_BEEF, 32'd7);
    set_write(1'b0, 0, '0);
    set_fetch(1, 0, 1'b1, 32'h99, 1'b1);
    cycle("stall2", 1'b1, 32'hDEAD_BEEF, 32'd7);
    flush = 1'b1;
    cycle("flush", 1'b0, 32'h0, 32'h0);
    flush = 1'b0;
    stall = 1'b0;
    set_fetch(5, 3, 1'b0, '0, 1'b1);
    cycle("wr_in_stall", 1'b1, 32'h1, 32'd7);

    // Same-cycle write/read on each port
    write_reg(7, 32'h1);
    set_fetch(7, 0, 1'b0, '0, 1'b1);
    set_write(1'b1, 7, 32'h2);
    cycle("same_cyc_a", 1'b1, BYP ? 32'h2 : 32'h1, 32'h0);
    set_write(1'b0, 0, '0);
    set_fetch(7, 7, 1'b0, '0, 1'b1);
    cycle("after_wr_r7", 1'b1, 32'h2, 32'h2);
    write_reg(8, 32'h9);
    set_fetch(0, 8, 1'b0, '0, 1'b1);
    set_write(1'b1, 8, 32'hA);
    cycle("same_cyc_b", 1'b1, 32'h0, BYP ? 32'hA : 32'h9);
    set_fetch(0, 9, 1'b1, 32'h77, 1'b1);
    set_write(1'b1, 9, 32'h55);
    cycle("same_cyc_const", 1'b1, 32'h0, 32'h77);
    set_fetch(0, 9, 1'b0, '0, 1'b1);
    set_write(1'b1, 0, 32'hFFFF_FFFF);
    cycle("same_cyc_r0", 1'b1, 32'h0, 32'h55);
    set_write(1'b0, 0, '0);

    // Out-of-range on the 16-register instance
    write_reg(20, 32'h5);
    set_fetch(20, 4, 1'b0, '0, 1'b1);
    cycle("oor_r32", 1'b1, 32'h5, 32'h0);
    check("oor16_a", a16, 32'h0);
    check("oor16_b", b16, 32'h0);
    check("oor16_valid", DW'(v16), 32'h1);
    set_fetch(20, 4, 1'b0, '0, 1'b1);
    set_write(1'b1, 20, 32'h6);
    cycle("oor_byp_r32", 1'b1, BYP ? 32'h6 : 32'h5, 32'h0);
    check("oor16_byp_a", a16, 32'h0);
    set_write(1'b0, 0, '0);
    set_fetch(5, 3, 1'b0, '0, 1'b1);
    cycle("keep_r32", 1'b1, 32'h1, 32'd7);
    check("keep16_a", a16, 32'h1);
    check("keep16_b", b16, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
